// File: rtl/mmio_bridge_n_pkg.sv
// Shared types and constants for the MMIO bridge.
// FSM encoding, access-size code and the default two-device address map.
package mmio_bridge_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    localparam logic [2:0] DM_MODE_WORD = 3'd0;
    localparam int IDX_W   = 3;
    localparam int IRQ_W   = 6;
    localparam int CNT_W   = 8;

    localparam logic [63:0] DEF_DEV_BASE = {32'h0000_7F10, 32'h0000_7F00};
    localparam logic [63:0] DEF_DEV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0};

endpackage

// File: rtl/mmio_decode.sv
// Address decoder: base/mask match per device.
// The lowest matching device index wins.
module mmio_decode
    import mmio_bridge_n_pkg::*;
#(
    parameter int NUM_DEV = 2,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = DEF_DEV_BASE,
    parameter logic [NUM_DEV*32-1:0] DEV_MASK = DEF_DEV_MASK
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Walk downwards so the lowest index is the last to overwrite.
        for (int k = NUM_DEV - 1; k >= 0; k--) begin
            if ((addr & DEV_MASK[32*k +: 32]) == DEV_BASE[32*k +: 32]) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mmio_bridge_n.sv
// Multi-cycle MMIO bridge between the CPU data port and NUM_DEV devices,
// with abort, timeout and interrupt aggregation onto hwirq[7:2].
module mmio_bridge_n
    import mmio_bridge_n_pkg::*;
#(
    parameter int NUM_DEV = 2,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = DEF_DEV_BASE,
    parameter logic [NUM_DEV*32-1:0] DEV_MASK = DEF_DEV_MASK,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_write_data,
    input  logic                   dev_write_enable,
    input  logic [2:0]             dm_mode,
    input  logic                   bridge_stop,
    output logic                   bridge_valid,
    output logic                   cpu_ready,
    output logic                   bus_err,
    output logic [31:0]            cpu_read_result,
    output logic [NUM_DEV-1:0]     dev_sel,
    output logic [NUM_DEV-1:0]     dev_we,
    output logic [31:0]            dev_addr,
    output logic [31:0]            dev_wdata,
    input  logic [NUM_DEV*32-1:0]  dev_rdata,
    input  logic [NUM_DEV-1:0]     dev_ack,
    input  logic [NUM_DEV-1:0]     dev_irq,
    output logic [IRQ_W-1:0]       hwirq
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   we_q, we_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DEV-1:0]     sel_q, sel_d;
    logic [NUM_DEV-1:0]     wen_q, wen_d;
    logic [IRQ_W-1:0]       irq_q, irq_d;

    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   ack_sel;
    logic [31:0]            rdata_sel;

    mmio_decode #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_decode (
        .addr (cpu_addr),
        .hit  (hit),
        .idx  (hit_idx)
    );

    assign bridge_valid = cpu_req & hit & (cpu_addr[1:0] == 2'b00)
                        & (dm_mode == DM_MODE_WORD);

    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (idx_q == IDX_W'(k)) begin
                ack_sel   = dev_ack[k];
                rdata_sel = dev_rdata[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            wen_q   <= '0;
            irq_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            wen_q   <= wen_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bridge_valid && !bridge_stop) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_write_data;
                    we_d    = dev_write_enable;
                    idx_d   = hit_idx;
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Abort beats a same-cycle ack and the timeout.
                if (bridge_stop) begin
                    state_d = ST_IDLE;
                end else if (ack_sel) begin
                    if (!we_q) rdata_d = rdata_sel;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d = '0;
        wen_d = '0;
        irq_d = '0;
        if (state_d == ST_ACCESS) begin
            for (int k = 0; k < NUM_DEV; k++) begin
                sel_d[k] = (idx_d == IDX_W'(k));
            end
            wen_d = sel_d & {NUM_DEV{we_d}};
        end
        irq_d[NUM_DEV-1:0] = dev_irq;
    end

    assign cpu_ready       = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign bus_err         = (state_q == ST_ERR);
    assign cpu_read_result = rdata_q;
    assign dev_sel         = sel_q;
    assign dev_we          = wen_q;
    assign dev_addr        = addr_q;
    assign dev_wdata       = wdata_q;
    assign hwirq           = irq_q;

endmodule

// File: tb/tb_mmio_bridge_n.sv
// Self-checking bench for mmio_bridge_n: directed vector table,
// hand-written reset/irq sequences and randomized transactions.
module tb_mmio_bridge_n;

    localparam int NUM_DEV = 2;
    localparam int TO      = 4;

    localparam int K_ILL   = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;
    localparam int K_ABORT = 3;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [2:0]  mode;
        int          ack_at;
        int          stop_at;
        logic [31:0] rdata;
        int          kind;
        logic [31:0] exp_res;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cpu_req;
    logic [31:0]           cpu_addr;
    logic [31:0]           cpu_write_data;
    logic                  dev_write_enable;
    logic [2:0]            dm_mode;
    logic                  bridge_stop;
    logic                  bridge_valid;
    logic                  cpu_ready;
    logic                  bus_err;
    logic [31:0]           cpu_read_result;
    logic [NUM_DEV-1:0]    dev_sel;
    logic [NUM_DEV-1:0]    dev_we;
    logic [31:0]           dev_addr;
    logic [31:0]           dev_wdata;
    logic [NUM_DEV*32-1:0] dev_rdata;
    logic [NUM_DEV-1:0]    dev_ack;
    logic [NUM_DEV-1:0]    dev_irq;
    logic [5:0]            hwirq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_res = '0;

    always #5 clk = ~clk;

    mmio_bridge_n #(
        .NUM_DEV (NUM_DEV),
        .TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_req          (cpu_req),
        .cpu_addr         (cpu_addr),
        .cpu_write_data   (cpu_write_data),
        .dev_write_enable (dev_write_enable),
        .dm_mode          (dm_mode),
        .bridge_stop      (bridge_stop),
        .bridge_valid     (bridge_valid),
        .cpu_ready        (cpu_ready),
        .bus_err          (bus_err),
        .cpu_read_result  (cpu_read_result),
        .dev_sel          (dev_sel),
        .dev_we           (dev_we),
        .dev_addr         (dev_addr),
        .dev_wdata        (dev_wdata),
        .dev_rdata        (dev_rdata),
        .dev_ack          (dev_ack),
        .dev_irq          (dev_irq),
        .hwirq            (hwirq)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Address map of the default configuration: 0x7F00..0x7F0F dev0, 0x7F10..0x7F1F dev1.
    function automatic int model_dev(input logic [31:0] a);
        if (a >= 32'h7F00 && a <= 32'h7F0F) return 0;
        if (a >= 32'h7F10 && a <= 32'h7F1F) return 1;
        return -1;
    endfunction

    function automatic int model_kind(input vec_t v);
        int last;
        last = TO - 1;
        if (model_dev(v.addr) < 0 || v.addr % 4 != 0 || v.mode != 3'd0) return K_ILL;
        if (v.stop_at >= 0 && v.stop_at <= last && (v.ack_at < 0 || v.stop_at <= v.ack_at))
            return K_ABORT;
        if (v.ack_at >= 0 && v.ack_at <= last) return K_DONE;
        return K_ERR;
    endfunction

    task automatic run_txn(input vec_t v);
        int dev;
        int end_i;
        logic [NUM_DEV-1:0] oh;
        logic [NUM_DEV-1:0] noise;
        dev = model_dev(v.addr);
        @(negedge clk);
        cpu_req          = 1'b1;
        cpu_addr         = v.addr;
        cpu_write_data   = v.wdata;
        dev_write_enable = v.we;
        dm_mode          = v.mode;
        bridge_stop      = 1'b0;
        dev_ack          = '0;
        dev_rdata        = {$urandom, $urandom};
        #1;
        chk("bridge_valid", 32'(bridge_valid), 32'(v.kind != K_ILL));
        if (v.kind == K_ILL) begin
            repeat (3) begin
                @(negedge clk);
                chk("ill_valid", 32'(bridge_valid), 0);
                chk("ill_sel", 32'(dev_sel), 0);
                chk("ill_ready", 32'(cpu_ready), 0);
            end
            cpu_req = 1'b0;
            chk("ill_res", cpu_read_result, v.exp_res);
            return;
        end
        end_i = (v.kind == K_ABORT) ? v.stop_at :
                (v.kind == K_DONE)  ? v.ack_at  : TO - 1;
        oh = '0;
        oh[dev] = 1'b1;
        for (int i = 0; i <= end_i; i++) begin
            @(negedge clk);
            chk("acc_sel", 32'(dev_sel), 32'(oh));
            chk("acc_we", 32'(dev_we), v.we ? 32'(oh) : 0);
            chk("acc_addr", dev_addr, v.addr);
            chk("acc_wdata", dev_wdata, v.wdata);
            chk("acc_ready", 32'(cpu_ready), 0);
            // Disturb CPU-side inputs and other-device acks; neither may matter now.
            cpu_addr       = $urandom;
            cpu_write_data = $urandom;
            noise          = NUM_DEV'($urandom) & ~oh;
            dev_ack        = noise | ((i == v.ack_at) ? oh : '0);
            dev_rdata      = {$urandom, $urandom};
            dev_rdata[dev*32 +: 32] = v.rdata;
            bridge_stop    = (i == v.stop_at);
        end
        @(negedge clk);
        dev_ack     = '0;
        bridge_stop = 1'b0;
        cpu_req     = 1'b0;
        chk("end_sel", 32'(dev_sel), 0);
        chk("end_ready", 32'(cpu_ready), 32'(v.kind != K_ABORT));
        chk("end_buserr", 32'(bus_err), 32'(v.kind == K_ERR));
        chk("end_res", cpu_read_result, v.exp_res);
        @(negedge clk);
        chk("post_ready", 32'(cpu_ready), 0);
        chk("post_buserr", 32'(bus_err), 0);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_addr = 0; cpu_write_data = 0; dev_write_enable = 0;
        dm_mode = 0; bridge_stop = 0; dev_rdata = '0; dev_ack = '0; dev_irq = '0;

        tbl[0] = '{32'h7F14, 0, 32'h0,         3'd0,  3, -1, 32'h1234_5678, K_DONE,  32'h1234_5678};
        tbl[1] = '{32'h7F00, 1, 32'hCAFE_F00D, 3'd0,  0, -1, 32'h5555_5555, K_DONE,  32'h1234_5678};
        tbl[2] = '{32'h7F02, 0, 32'h0,         3'd0,  0, -1, 32'h0,         K_ILL,   32'h1234_5678};
        tbl[3] = '{32'h7F00, 0, 32'h0,         3'd1,  0, -1, 32'h0,         K_ILL,   32'h1234_5678};
        tbl[4] = '{32'h3000, 0, 32'h0,         3'd0,  0, -1, 32'h0,         K_ILL,   32'h1234_5678};
        tbl[5] = '{32'h7F04, 0, 32'h0,         3'd0, -1, -1, 32'h0,         K_ERR,   32'h0};
        tbl[6] = '{32'h7F10, 0, 32'h0,         3'd0,  1,  1, 32'hDEAD_BEEF, K_ABORT, 32'h0};
        tbl[7] = '{32'h7F18, 0, 32'h0,         3'd0,  0, -1, 32'hA5A5_A5A5, K_DONE,  32'hA5A5_A5A5};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(cpu_ready), 0);
        chk("rst_buserr", 32'(bus_err), 0);
        chk("rst_sel", 32'(dev_sel), 0);
        chk("rst_we", 32'(dev_we), 0);
        chk("rst_addr", dev_addr, 0);
        chk("rst_wdata", dev_wdata, 0);
        chk("rst_res", cpu_read_result, 0);
        chk("rst_hwirq", 32'(hwirq), 0);

        foreach (tbl[i]) run_txn(tbl[i]);

        // Interrupt path is registered once.
        @(negedge clk);
        dev_irq = 2'b10;
        #1 chk("irq_same_cycle", 32'(hwirq), 0);
        @(negedge clk);
        chk("irq_one_later", 32'(hwirq), 32'h02);

        // Reset in the middle of an access.
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h7F14; dm_mode = 0; dev_write_enable = 1;
        cpu_write_data = 32'h0BAD_0BAD;
        @(negedge clk);
        chk("mid_sel", 32'(dev_sel), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b0;
        chk("mrst_sel", 32'(dev_sel), 0);
        chk("mrst_we", 32'(dev_we), 0);
        chk("mrst_ready", 32'(cpu_ready), 0);
        chk("mrst_addr", dev_addr, 0);
        chk("mrst_wdata", dev_wdata, 0);
        chk("mrst_res", cpu_read_result, 0);
        chk("mrst_hwirq", 32'(hwirq), 0);
        @(negedge clk);
        chk("mrst_idle_sel", 32'(dev_sel), 0);
        chk("irq_after_rst", 32'(hwirq), 32'h02);
        dev_irq = 2'b00;
        model_res = '0;

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    rv.addr = 32'h7F00 + 4 * $urandom_range(0, 3);
                2, 3:    rv.addr = 32'h7F10 + 4 * $urandom_range(0, 3);
                4:       rv.addr = 32'h7F00 + $urandom_range(0, 31);
                default: rv.addr = $urandom;
            endcase
            rv.we      = 1'($urandom);
            rv.wdata   = $urandom;
            rv.mode    = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rv.ack_at  = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TO + 1);
            rv.stop_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TO) : -1;
            rv.rdata   = $urandom;
            rv.kind    = model_kind(rv);
            if (rv.kind == K_DONE && !rv.we) model_res = rv.rdata;
            else if (rv.kind == K_ERR)       model_res = '0;
            rv.exp_res = model_res;
            run_txn(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mmio_bridge_n.md
Name: mmio_bridge_n

Overview:
- Parametrised memory-mapped I/O bridge between the CPU M-stage data port and NUM_DEV peripheral devices.
- Decodes the CPU address and runs a multi-cycle request/acknowledge transaction to one device, with abort and timeout.
- Aggregates device interrupt lines into the CPU hwirq[7:2] bus.
- Successor of the fixed single-cycle, two-device bridge: adds device count, address map, wait states, timeout and abort.

Parameters:
NUM_DEV, 2, number of attached devices; legal range 1..6.
DEV_BASE, {32'h7F10, 32'h7F00}, packed NUM_DEV*32 base addresses; device k uses bits [32k+31:32k].
DEV_MASK, {32'hFFFF_FFF0, 32'hFFFF_FFF0}, packed NUM_DEV*32 masks; device k hits when (addr & mask_k) == base_k.
TIMEOUT, 16, cycles in ACCESS without dev_ack before a bus error; legal range 1..255.

Ports:
clk  in  1  clock
rst  in  1  reset
cpu_req  in  1  access strobe, held by the CPU until cpu_ready or abort
cpu_addr  in  32  byte address
cpu_write_data  in  32  store data
dev_write_enable  in  1  1 = store, 0 = load
dm_mode  in  3  access size; only 3'd0 (word) is legal for devices
bridge_stop  in  1  abort the access in flight (exception flush)
bridge_valid  out  1  combinational: the current request is legal
cpu_ready  out  1  one-cycle completion pulse
bus_err  out  1  one-cycle pulse together with cpu_ready on timeout
cpu_read_result  out  32  load data, held until the next completion
dev_sel  out  NUM_DEV  one-hot device select
dev_we  out  NUM_DEV  one-hot device write strobe
dev_addr  out  32  latched address
dev_wdata  out  32  latched store data
dev_rdata  in  NUM_DEV*32  device read data
dev_ack  in  NUM_DEV  per-device acknowledge
dev_irq  in  NUM_DEV  per-device level interrupt
hwirq  out  6  CPU interrupt lines [7:2]

Behaviour:
- Reset: one clock, synchronous, active-high. All registered outputs go to 0, FSM to IDLE, timeout counter to 0.
- Legality: bridge_valid = cpu_req & (addr hits at least one device) & cpu_addr[1:0]==0 & dm_mode==0.
  - If more than one device hits, the lowest index wins.
  - bridge_valid is evaluated in every state.
- IDLE:
  - cpu_req & bridge_valid: latch address, write data, write flag and device index; clear the counter; go to ACCESS.
  - cpu_req & !bridge_valid: stay in IDLE, no device strobes, no cpu_ready. The CPU raises the exception.
- ACCESS:
  - dev_sel[idx]=1 and dev_we[idx]=latched write flag, both registered, both held continuously in this state.
  - dev_ack[idx]: capture dev_rdata[idx] into cpu_read_result (loads only; stores leave it unchanged); go to DONE.
  - Acks from non-selected devices are ignored. An ack in the first ACCESS cycle gives a minimum latency of request-to-ready = 2 cycles.
  - Counter increments every ACCESS cycle without ack. When it reaches TIMEOUT-1 with no ack, go to ERR.
- DONE: cpu_ready=1 for one cycle, strobes low, go to IDLE. A new request is accepted on the following cycle.
- ERR: cpu_ready=1 and bus_err=1 for one cycle, cpu_read_result=0, go to IDLE.
- Abort:
  - bridge_stop in ACCESS: drop the strobes next cycle and go to IDLE, with no cpu_ready and no read-data update. This applies even if dev_ack is in the same cycle; abort wins.
  - bridge_stop in IDLE blocks acceptance of cpu_req that cycle.
  - bridge_stop in DONE or ERR has no effect.
- Interrupts: hwirq[k] = dev_irq[k] registered once, for k < NUM_DEV; remaining bits are 0. Reset clears them.
- The address and data latches do not change outside the IDLE→ACCESS transition.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, ACCESS, DONE, ERR).
  - DM_MODE_WORD constant.
  - Default device base and mask constants.
- One sub-module, mmio_decode: combinational; takes the address plus DEV_BASE/DEV_MASK and outputs a hit flag and a priority-encoded index.
- FSM, counter and IRQ register live in the top module.

Test Plan:
- Word load from device 1 (0x7F14) with ack 3 cycles after select, rdata 0x1234_5678 → cpu_ready pulses exactly once; cpu_read_result=0x1234_5678; dev_sel=2'b10 during ACCESS only.
- Store 0xCAFE_F00D to 0x7F00 with same-cycle ack → dev_we=2'b01 for 1 cycle; cpu_ready 2 cycles after cpu_req; cpu_read_result unchanged.
- Illegal requests: addr 0x7F02, dm_mode=1 at 0x7F00, addr 0x3000 → bridge_valid=0; no dev_sel; no cpu_ready; FSM stays IDLE.
- No ack, TIMEOUT=4 → ERR after 4 ACCESS cycles; cpu_ready=bus_err=1 for one cycle; cpu_read_result=0.
- bridge_stop in the 2nd ACCESS cycle, coinciding with dev_ack → no cpu_ready; read data not updated; IDLE next cycle; a following request completes normally.
- dev_irq=2'b10 → hwirq=6'b000010 one cycle later; rst in mid-ACCESS → all outputs 0 and IDLE on the next edge.
